key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the hold time in CLK cycles from press_pulse to long_pulse (1 s at 50 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning the auto-repeat period in CLK cycles after long_pulse (200 ms); legal values are 2 and above.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RSTn, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port key_value, input, 4 bits: debounced key levels from the key scanner; bit i is 1 while key i is held.
REQ-006 SHALL have port press_pulse, output, 4 bits: a one-cycle pulse on the tracked key's bit when that key is pressed.
REQ-007 SHALL have port release_pulse, output, 4 bits: a one-cycle pulse on the tracked key's bit when that key is released.
REQ-008 SHALL have port long_pulse, output, 4 bits: a one-cycle pulse when the tracked key has been held for LONG_CYCLES.
REQ-009 SHALL have port repeat_pulse, output, 4 bits: a one-cycle auto-repeat pulse while the key is held past long.
REQ-010 SHALL have port key_active, output, 1 bit: high while a key is being tracked.
REQ-011 SHALL have port key_code, output, 2 bits: the index of the tracked key; valid only while key_active is high.

Function
REQ-012 SHALL register key_value into k_q every cycle; the FSM decides only on k_q, and all outputs SHALL be registered.
REQ-013 SHALL implement the states IDLE, HELD and LONG.
REQ-014 SHALL, in IDLE, when any bit of k_q is 1, go to HELD, take the lowest set index as the tracked key, load key_code, set key_active, assert press_pulse[idx] and clear hold_cnt.
REQ-015 SHALL give a latency of 2 cycles: key_value high before edge E0 gives press_pulse high for exactly the cycle after edge E1.
REQ-016 SHALL, in HELD, increment hold_cnt while k_q[idx] is 1; on the cycle when hold_cnt reaches LONG_CYCLES-1 it SHALL assert long_pulse[idx], go to LONG and clear rep_cnt, so that long_pulse comes exactly LONG_CYCLES cycles after press_pulse.
REQ-017 SHALL, in LONG, increment rep_cnt while the key is held; when rep_cnt reaches REPEAT_CYCLES-1 it SHALL assert repeat_pulse[idx] and return rep_cnt to 0, so a pulse occurs every REPEAT_CYCLES cycles without limit.
REQ-018 SHALL, in HELD or LONG, when k_q[idx] is 0, assert release_pulse[idx], clear key_active and go to IDLE, and no long or repeat pulse SHALL be issued in that cycle.
REQ-019 SHALL ignore other keys while a key is tracked; after a release, a key still held SHALL produce a fresh press no earlier than the cycle after release_pulse.
REQ-020 SHALL, if several keys rise in the same cycle in IDLE, track only the lowest index; no pulses are issued for the others until they are re-evaluated after release.
REQ-021 SHALL assert at most one bit across all pulse outputs in any cycle, and each pulse SHALL last exactly one cycle.
REQ-022 SHALL size hold_cnt and rep_cnt as $clog2 of the respective parameter; they never wrap past their terminal value.

Reset
REQ-023 SHALL, while RSTn is 1 at a rising edge, force state to IDLE, k_q to 0, hold_cnt and rep_cnt to 0, and every pulse output, key_active and key_code to 0.
REQ-024 SHALL, on reset mid-operation, drop any in-flight event with no release_pulse issued; a key held through reset deassertion SHALL give press_pulse 2 cycles after RSTn falls.

Configuration
REQ-025 SHALL, with KEY_REPEAT_EN defined, implement auto-repeat exactly as in REQ-017.
REQ-026 SHALL, with KEY_REPEAT_EN undefined, omit rep_cnt, tie repeat_pulse to 0, and keep LONG only until release; all other behaviour is unchanged.

Verification (LONG_CYCLES=10, REPEAT_CYCLES=4, KEY_REPEAT_EN defined unless noted)
REQ-027 SHALL test a short press: key_value=0001 for 5 cycles, then 0000; press_pulse=0001 in cycle 2, release_pulse=0001 2 cycles after the fall, and long_pulse never asserts.
REQ-028 SHALL test a long press with repeat: key_value=0100 held for 25 cycles; press_pulse at t, long_pulse=0100 at t+10, repeat_pulse=0100 at t+14, t+18 and t+22, key_code=2 throughout, then release_pulse.
REQ-029 SHALL test priority: key_value goes from 0000 directly to 1010; only bit 1 gets press_pulse and key_code=1; when bit 1 drops and bit 3 stays, release_pulse=0010 is followed by press_pulse=1000 no earlier than the next cycle.
REQ-030 SHALL test reset mid-hold: RSTn=1 for 1 cycle at t+12 of a held key; all outputs are 0 the next cycle with no release_pulse, and press_pulse is seen 2 cycles after RSTn falls.
REQ-031 SHALL test the build with KEY_REPEAT_EN undefined: key_value=0001 held for 30 cycles gives one long_pulse at t+10 and repeat_pulse=0 throughout.

Source files
------------

// File: rtl/key_event_decoder.sv
// Key event decoder: press, release, long-press and auto-repeat pulses for a 4-key pad.
// Define KEY_REPEAT_EN to build the auto-repeat counter; otherwise repeat_pulse is tied low.
module key_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] key_value,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] long_pulse,
    output logic [3:0] repeat_pulse,
    output logic       key_active,
    output logic [1:0] key_code
);

    localparam int HW = $clog2(LONG_CYCLES);

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_event_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    k_q;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [3:0]    press_nx, release_nx, long_nx;
    logic          active_nx;
    logic [1:0]    code_nx;
    logic [1:0]    low_idx;
    logic          held;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep_cnt, rep_nx;
    logic [3:0]    repeat_nx;
`endif

    assign held = k_q[key_code];

    // Later assignments win, so the lowest set index is selected.
    always_comb begin
        low_idx = 2'd0;
        if (k_q[3]) low_idx = 2'd3;
        if (k_q[2]) low_idx = 2'd2;
        if (k_q[1]) low_idx = 2'd1;
        if (k_q[0]) low_idx = 2'd0;
    end

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        press_nx   = '0;
        release_nx = '0;
        long_nx    = '0;
        active_nx  = key_active;
        code_nx    = key_code;
`ifdef KEY_REPEAT_EN
        rep_nx     = rep_cnt;
        repeat_nx  = '0;
`endif
        unique case (state)
            IDLE: begin
                if (|k_q) begin
                    state_nx          = HELD;
                    code_nx           = low_idx;
                    active_nx         = 1'b1;
                    press_nx[low_idx] = 1'b1;
                    hold_nx           = '0;
                end
            end
            HELD: begin
                if (!held) begin
                    release_nx[key_code] = 1'b1;
                    active_nx            = 1'b0;
                    state_nx             = IDLE;
                end else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                    long_nx[key_code] = 1'b1;
                    state_nx          = LONG;
`ifdef KEY_REPEAT_EN
                    rep_nx            = '0;
`endif
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (!held) begin
                    release_nx[key_code] = 1'b1;
                    active_nx            = 1'b0;
                    state_nx             = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                    repeat_nx[key_code] = 1'b1;
                    rep_nx              = '0;
                end else begin
                    rep_nx = rep_cnt + 1'b1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTn) begin
            state         <= IDLE;
            k_q           <= '0;
            hold_cnt      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            key_active    <= 1'b0;
            key_code      <= '0;
        end else begin
            state         <= state_nx;
            k_q           <= key_value;
            hold_cnt      <= hold_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_pulse    <= long_nx;
            key_active    <= active_nx;
            key_code      <= code_nx;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge CLK) begin
        if (RSTn) begin
            rep_cnt      <= '0;
            repeat_pulse <= '0;
        end else begin
            rep_cnt      <= rep_nx;
            repeat_pulse <= repeat_nx;
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random key traffic,
// scored against an elapsed-time event model through an expectation queue.
module tb_key_event_decoder;

    localparam int LC = 10;
    localparam int RC = 4;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RSTn = 1'b1;
    logic [3:0] key_value = '0;
    logic [3:0] press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic       key_active;
    logic [1:0] key_code;

    key_event_decoder #(
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .key_value    (key_value),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .key_active   (key_active),
        .key_code     (key_code)
    );

    always #5 CLK = ~CLK;

    // Pulses packed as {press, release, long, repeat}.
    typedef struct {
        int          cyc;
        logic [15:0] p;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         m_trk = 1'b0;
    int         m_idx = 0;
    int         m_t0 = 0;
    logic [3:0] m_kq = '0;

    task automatic push(int kind);
        ev_t e;
        e.cyc = cyc;
        e.p = '0;
        e.p[kind*4 + m_idx] = 1'b1;
        q.push_back(e);
    endtask

    // Model: events follow from the elapsed cycles since the press.
    task automatic step(logic [3:0] kv, logic rst);
        int d;
        key_value = kv;
        RSTn = rst;
        @(posedge CLK);
        cyc++;
        if (rst) begin
            m_trk = 1'b0;
            m_kq = '0;
        end else begin
            if (!m_trk) begin
                if (m_kq != 0) begin
                    for (int i = 3; i >= 0; i--)
                        if (m_kq[i]) m_idx = i;
                    m_trk = 1'b1;
                    m_t0 = cyc;
                    push(3);
                end
            end else if (!m_kq[m_idx]) begin
                push(2);
                m_trk = 1'b0;
            end else begin
                d = cyc - m_t0;
                if (d == LC) push(1);
                else if (REP && d > LC && (d - LC) % RC == 0) push(0);
            end
            m_kq = kv;
        end
        @(negedge CLK);
    endtask

    task automatic check_quiet(string name);
        checks++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse,
             key_active, key_code} !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h active=%b code=%0d, required all zero",
                     name, {press_pulse, release_pulse, long_pulse, repeat_pulse},
                     key_active, key_code);
        end
    endtask

    always @(negedge CLK) begin
        logic [15:0] p;
        p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
        if (q.size() > 0 && q[0].cyc == cyc) begin
            checks++;
            if (p !== q[0].p) begin
                errors++;
                $display("FAIL pulse cyc=%0d got=%h want=%h", cyc, p, q[0].p);
            end
            void'(q.pop_front());
        end else if (p !== 16'h0) begin
            checks++;
            errors++;
            $display("FAIL spurious_pulse cyc=%0d got=%h want=0000", cyc, p);
        end
        checks++;
        if (key_active !== m_trk) begin
            errors++;
            $display("FAIL key_active cyc=%0d got=%b want=%b", cyc, key_active, m_trk);
        end
        if (m_trk) begin
            checks++;
            if (key_code !== 2'(m_idx)) begin
                errors++;
                $display("FAIL key_code cyc=%0d got=%0d want=%0d", cyc, key_code, m_idx);
            end
        end
    end

    initial begin
        logic [3:0] kv;
        int         n;
        repeat (3) step(4'b0000, 1'b1);
        check_quiet("reset_state");

        repeat (5) step(4'b0001, 1'b0);
        repeat (6) step(4'b0000, 1'b0);

        repeat (25) step(4'b0100, 1'b0);
        repeat (4) step(4'b0000, 1'b0);

        repeat (3) step(4'b1010, 1'b0);
        repeat (4) step(4'b1000, 1'b0);
        repeat (3) step(4'b0000, 1'b0);

        repeat (13) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        check_quiet("reset_mid_hold");
        repeat (6) step(4'b0001, 1'b0);
        repeat (3) step(4'b0000, 1'b0);

        repeat (30) step(4'b0001, 1'b0);
        repeat (3) step(4'b0000, 1'b0);

        for (int s = 0; s < 200; s++) begin
            kv = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 30) == 0) step(kv, 1'b1);
            repeat (n) step(kv, 1'b0);
        end
        repeat (5) step(4'b0000, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
